// File: rtl/vga_timing_pkg.sv
// Raster timing constants and elaboration-time helpers shared by vga_timing_gen and its axis counters.
// Default numbers describe 640x480@60 (800x525 total); optional pix_ce gating is VGA_TIMING_CE_EN.
package vga_timing_pkg;

  localparam int DEF_CW       = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  // Smallest width able to represent n (at least 1 bit).
  function automatic int bits_for(input int n);
    int b;
    b = 1;
    for (int i = 0; i < 31; i++)
      if ((n >> i) != 0) b = i + 1;
    return b;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, wrap strobe, and next-count active/last flags.
// Sync is registered from the next count so it lines up with the count it accompanies.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter bit POL        = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          act_next,
  output logic          last_next,
  output logic          sync
);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW:0]   ACT_END = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SS      = (CW+1)'(SYNC_START);
  localparam logic [CW:0]   SE      = (CW+1)'(SYNC_START + SYNC_LEN);

  logic [CW-1:0] count_next;
  logic [CW:0]   nxt_w;
  logic          at_last;

  assign at_last = (count == LAST);
  assign wrap    = en && at_last;

  always_comb begin
    count_next = count;
    if (en) count_next = at_last ? '0 : count + CW'(1);
  end

  // One extra bit so window ends equal to 2**CW still compare correctly.
  assign nxt_w     = {1'b0, count_next};
  assign act_next  = (nxt_w < ACT_END);
  assign last_next = (count_next == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sync  <= ~POL;
    end else if (en) begin
      count <= count_next;
      sync  <= (nxt_w >= SS && nxt_w < SE) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: cascaded h/v axis counters with registered sync, display-enable and strobes.
// Define VGA_TIMING_CE_EN to add pix_ce; all state then advances only when pix_ce is high.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VGA_TIMING_CE_EN
  input  logic          pix_ce,
`endif
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          disp_en,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (bits_for(H_TOTAL - 1) > CW || bits_for(V_TOTAL - 1) > CW) begin : g_cw_check
      $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  logic advance;
`ifdef VGA_TIMING_CE_EN
  assign advance = pix_ce;
`else
  assign advance = 1'b1;
`endif

  logic h_wrap, h_act_next, h_last_next;
  logic v_wrap, v_act_next, v_last_next;

  vga_axis_counter #(
    .CW(CW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(sync_start(H_ACTIVE, H_FP)), .SYNC_LEN(H_SYNC), .POL(HS_POL)
  ) u_h (
    .clk(clk), .rst(rst), .en(advance),
    .count(h_count), .wrap(h_wrap), .act_next(h_act_next),
    .last_next(h_last_next), .sync(hsync)
  );

  // Vertical axis steps only on the horizontal wrap, so vsync changes at h_count==0.
  vga_axis_counter #(
    .CW(CW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(sync_start(V_ACTIVE, V_FP)), .SYNC_LEN(V_SYNC), .POL(VS_POL)
  ) u_v (
    .clk(clk), .rst(rst), .en(advance && h_wrap),
    .count(v_count), .wrap(v_wrap), .act_next(v_act_next),
    .last_next(v_last_next), .sync(vsync)
  );

  // A frame wrap can only happen together with a line wrap.
  assert property (@(posedge clk) disable iff (rst) v_wrap |-> h_wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_en   <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (advance) begin
      disp_en   <= h_act_next && v_act_next;
      line_end  <= h_last_next;
      frame_end <= h_last_next && v_last_next;
    end
  end

endmodule
